apple2_video_timing_gen: RTL and testbench
==========================================

# apple2_video_timing_gen

Parametrised successor to the Apple //e timing generator. It produces the CPU phase clocks, the 7M and colour-reference clocks, the horizontal and vertical scan counters, and the blanking, sync and burst gates. Unlike the current generator it has a real reset, selectable NTSC/PAL frame length, an optional long cycle, composite sync, a programmable line interrupt and a frame counter. It sits between the 14M clock source and the video address/shift logic and the CPU clock-enable fabric.

## Interface
Parameters:
- V_FIRST, 9'h0FA: vertical counter reload value. 9'h0FA gives NTSC (262 lines); 9'h0C8 gives PAL (312 lines). Lines per frame = 512 − V_FIRST.
- LONG_CYCLE, 1: 1 makes the last cycle of each line 16 clocks; 0 makes every cycle 14 clocks.
- FRAME_W, 8: width of FRAME_CNT.

Ports:
- CLK_14M  in  1: master clock, 14.31818 MHz.
- RESET_N  in  1: asynchronous, active-low reset.
- BURST_EN  in  1: enables the colour-burst gate (driven low in text mode).
- VINT_LINE  in  9: V value on which VINT fires.
- CLK_7M  out  1: toggles every clock.
- COLOR_REF  out  1: 3.58 MHz reference.
- Q3  out  1: 2 MHz phase clock.
- PHI0  out  1: CPU phase clock.
- CPU_CE  out  1: high during the final clock of each CPU cycle.
- H_CNT  out  7: horizontal counter.
- V_CNT  out  9: vertical counter.
- HBLANK  out  1: horizontal blank.
- VBLANK  out  1: vertical blank.
- WNDW_N  out  1: low only inside the active window.
- HSYNC  out  1: horizontal sync.
- VSYNC  out  1: vertical sync.
- SYNC_N  out  1: composite sync, active low.
- BURST  out  1: colour-burst gate.
- VINT  out  1: line interrupt pulse, one CLK_14M wide.
- FRAME_CNT  out  FRAME_W: frame counter.

## Operation
- Single clock domain (CLK_14M). Every output is a register. RESET_N clears all state immediately, including when a reset arrives mid-cycle or mid-frame.
- Phase counter PH, 4 bits:
  - Counts 0..13 on every CPU cycle.
  - Counts 0..15 when LONG_CYCLE=1 and H_CNT=7'h7F.
  - The final phase is 13, or 15 in a long cycle. From the final phase PH returns to 0.
- Clock outputs:
  - CLK_7M ← ~CLK_7M.
  - COLOR_REF ← COLOR_REF ^ CLK_7M.
  - Both are free-running and take no account of the long cycle.
- Phase decodes (outputs register the decode of the next PH):
  - PHI0 = 1 for PH 7..15.
  - Q3 = 1 for PH 0..3 and 7..10.
  - CPU_CE = 1 when PH is final.
- Counter step, on the edge where PH leaves its final phase:
  - H sequence: 7'h00 → 7'h40 → 7'h41 … 7'h7F → 7'h00. That is 65 cycles per line.
  - On 7'h7F → 7'h00, V_CNT increments. When V_CNT=9'h1FF it instead reloads V_FIRST, and FRAME_CNT increments (wraps modulo 2^FRAME_W).
  - V_CNT changes at no other time.
- Gates are evaluated on the new H/V values and registered on the same edge as the counter step:
  - HBL = ~(H5 | (H4 & H3)).
  - VBL = ~V8 | (V7 & V6).
  - HBLANK = HBL.
  - VBLANK = VBL.
  - WNDW_N = HBL | VBL.
  - HSYNC = HBL & H3 & ~H2.
  - VSYNC = VBL & (V[5:2]=4'b1000) & (H5 | H4 | H3).
  - SYNC_N = ~(HSYNC | VSYNC).
  - BURST = HBL & H3 & H2 & BURST_EN.
- VINT:
  - High for exactly one clock, on the step where the new H=7'h00 and the new V=VINT_LINE.
  - A VINT_LINE value outside the counted V range never fires.
  - VINT_LINE is sampled only at that step.

## Timing
- Reset values:
  - PH=0, H_CNT=7'h00, V_CNT=V_FIRST, FRAME_CNT=0.
  - CLK_7M=0, COLOR_REF=0.
  - Q3=1, PHI0=0, CPU_CE=0.
  - HBLANK=1, VBLANK=1, WNDW_N=1, HSYNC=0, VSYNC=0, SYNC_N=1, BURST=0, VINT=0.
- First CPU_CE comes 13 clocks after reset is released. First counter step comes at clock 14.
- Line length is 64×14+16 = 912 clocks with LONG_CYCLE=1, and 910 with LONG_CYCLE=0.
- Frame length is (512 − V_FIRST) lines.
- Gate outputs change on the same edge as H_CNT/V_CNT, so there is zero latency relative to the counters.
- At the simultaneous wrap of H (7'h7F→7'h00) and V (9'h1FF→V_FIRST):
  - V reloads rather than incrementing to 9'h000.
  - FRAME_CNT and VINT (if VINT_LINE=V_FIRST) update on the same edge.
- An asynchronous reset asserted during the long cycle or during VINT takes effect immediately. No pulse completes.

## Test plan
- Reset release, default parameters: Q3/PHI0 follow the pattern 1111000 / 0000000 then 1111000 / 1111111. CPU_CE is first high at clock 13. H_CNT=7'h40 after clock 14.
- Line measurement, NTSC defaults: HSYNC rising edges are 912 clocks apart. The H=7'h7F cycle has PHI0 high for 9 clocks. Rerun with LONG_CYCLE=0: spacing is 910 clocks.
- Frame measurement: V_FIRST=9'h0FA gives FRAME_CNT increments every 238944 clocks. V_FIRST=9'h0C8 gives increments every 284544 clocks. V_CNT never holds 9'h000–9'h0F9 in the NTSC case.
- Windowing: over one frame, WNDW_N is low for exactly 40 cycles × 192 lines (H 7'h58–7'h7F, V 9'h100–9'h1BF). VSYNC is asserted only for V 9'h1E0–9'h1E3.
- VINT: VINT_LINE=9'h1C0 gives exactly one 1-clock pulse per frame, when V_CNT becomes 9'h1C0. VINT_LINE=9'h000 with NTSC gives no pulse.
- Asynchronous reset at a random point (e.g. mid long cycle, V=9'h1FF): outputs return to their reset values without waiting for a clock edge. The following sequence is identical to the sequence after power-on reset.

Source files
------------

// File: rtl/apple2_video_timing_gen.sv
// apple2_video_timing_gen: Apple //e style phase clocks, scan counters, blank/sync/burst gates, line IRQ, frame count
//   CLK_14M, RESET_N (async, active low), BURST_EN, VINT_LINE[8:0]
//   -> CLK_7M, COLOR_REF, Q3, PHI0, CPU_CE, H_CNT[6:0], V_CNT[8:0], HBLANK, VBLANK,
//      WNDW_N, HSYNC, VSYNC, SYNC_N, BURST, VINT, FRAME_CNT[FRAME_W-1:0]
module apple2_video_timing_gen #(
  parameter logic [8:0] V_FIRST    = 9'h0FA,
  parameter bit         LONG_CYCLE = 1'b1,
  parameter int         FRAME_W    = 8
) (
  input  logic               CLK_14M,
  input  logic               RESET_N,
  input  logic               BURST_EN,
  input  logic [8:0]         VINT_LINE,
  output logic               CLK_7M,
  output logic               COLOR_REF,
  output logic               Q3,
  output logic               PHI0,
  output logic               CPU_CE,
  output logic [6:0]         H_CNT,
  output logic [8:0]         V_CNT,
  output logic               HBLANK,
  output logic               VBLANK,
  output logic               WNDW_N,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               SYNC_N,
  output logic               BURST,
  output logic               VINT,
  output logic [FRAME_W-1:0] FRAME_CNT
);
  logic [3:0] ph, ph_nxt, ph_fin;
  logic       step;
  logic [6:0] h_nxt;
  logic [8:0] v_nxt;
  logic       hbl, vbl, hs, vs;
  // H_CNT is stable whenever ph_nxt can be final, so the current line position decides both finals
  always_comb begin
    ph_fin = (LONG_CYCLE && H_CNT == 7'h7F) ? 4'd15 : 4'd13;
    step   = ph == ph_fin;
    ph_nxt = step ? 4'd0 : ph + 4'd1;
    h_nxt  = H_CNT == 7'h00 ? 7'h40 : H_CNT + 7'd1;
    v_nxt  = H_CNT != 7'h7F ? V_CNT : V_CNT == 9'h1FF ? V_FIRST : V_CNT + 9'd1;
    hbl    = ~(h_nxt[5] | (h_nxt[4] & h_nxt[3]));
    vbl    = ~v_nxt[8] | (v_nxt[7] & v_nxt[6]);
    hs     = hbl & h_nxt[3] & ~h_nxt[2];
    vs     = vbl & (v_nxt[5:2] == 4'b1000) & (h_nxt[5] | h_nxt[4] | h_nxt[3]);
  end
  always_ff @(posedge CLK_14M or negedge RESET_N)
    if (!RESET_N) begin
      ph        <= 4'd0;
      CLK_7M    <= 1'b0;
      COLOR_REF <= 1'b0;
      Q3        <= 1'b1;
      PHI0      <= 1'b0;
      CPU_CE    <= 1'b0;
      H_CNT     <= 7'h00;
      V_CNT     <= V_FIRST;
      FRAME_CNT <= '0;
      HBLANK    <= 1'b1;
      VBLANK    <= 1'b1;
      WNDW_N    <= 1'b1;
      HSYNC     <= 1'b0;
      VSYNC     <= 1'b0;
      SYNC_N    <= 1'b1;
      BURST     <= 1'b0;
      VINT      <= 1'b0;
    end else begin
      ph        <= ph_nxt;
      CLK_7M    <= ~CLK_7M;
      COLOR_REF <= COLOR_REF ^ CLK_7M;
      PHI0      <= ph_nxt >= 4'd7;
      Q3        <= (ph_nxt <= 4'd3) || (ph_nxt >= 4'd7 && ph_nxt <= 4'd10);
      CPU_CE    <= ph_nxt == ph_fin;
      VINT      <= 1'b0;
      if (step) begin
        H_CNT  <= h_nxt;
        V_CNT  <= v_nxt;
        HBLANK <= hbl;
        VBLANK <= vbl;
        WNDW_N <= hbl | vbl;
        HSYNC  <= hs;
        VSYNC  <= vs;
        SYNC_N <= ~(hs | vs);
        BURST  <= hbl & h_nxt[3] & h_nxt[2] & BURST_EN;
        VINT   <= h_nxt == 7'h00 && v_nxt == VINT_LINE;
        if (H_CNT == 7'h7F && V_CNT == 9'h1FF) FRAME_CNT <= FRAME_CNT + FRAME_W'(1);
      end
    end
endmodule

// File: tb/tb_apple2_video_timing_gen.sv
// tb_apple2_video_timing_gen: scoreboard bench comparing three generator variants against a line/frame position model
module tb_apple2_video_timing_gen;
  logic             CLK_14M = 1'b0;
  logic             RESET_N = 1'b0;
  wire [2:0][36:0]  obs;
  typedef logic [2:0][36:0] exp_t;
  exp_t             sb[$];
  int               n = 0, n_tests = 0, n_fail = 0;
  int               first_ce, vint0, wnd0, vint2, vmin;
  int               last_hs[2];
  logic [1:0]       prev_hs;

  always #5 CLK_14M = ~CLK_14M;

  // variant 0: short frame, long cycle; 1: short frame, no long cycle, burst off; 2: default NTSC
  for (genvar g = 0; g < 3; g++) begin : dut
    apple2_video_timing_gen #(
      .V_FIRST(g == 2 ? 9'h0FA : 9'h1BE), .LONG_CYCLE(g != 1), .FRAME_W(8)
    ) u (
      .CLK_14M(CLK_14M), .RESET_N(RESET_N), .BURST_EN(g != 1),
      .VINT_LINE(g == 2 ? 9'h000 : 9'h1C0),
      .CLK_7M(obs[g][36]), .COLOR_REF(obs[g][35]), .Q3(obs[g][34]), .PHI0(obs[g][33]),
      .CPU_CE(obs[g][32]), .H_CNT(obs[g][31:25]), .V_CNT(obs[g][24:16]),
      .HBLANK(obs[g][15]), .VBLANK(obs[g][14]), .WNDW_N(obs[g][13]), .HSYNC(obs[g][12]),
      .VSYNC(obs[g][11]), .SYNC_N(obs[g][10]), .BURST(obs[g][9]), .VINT(obs[g][8]),
      .FRAME_CNT(obs[g][7:0])
    );
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // expected outputs n clocks after reset release, derived from position within line and frame
  function automatic logic [36:0] model(int t, int g);
    int vf, ln, p, k, c, ph, fin, h, v, fr, vl;
    logic lng, hbl, vbl, hs, vs, q3;
    logic [6:0] hb;
    logic [8:0] vb;
    logic [7:0] gt, fb;
    vf = g == 2 ? 'h0FA : 'h1BE;
    vl = g == 2 ? 0 : 'h1C0;
    lng = g != 1;
    ln = lng ? 912 : 910;
    p = t % ln;
    k = t / ln;
    c = p / 14;
    if (c > 64) c = 64;
    ph = p - 14 * c;
    fin = (lng && c == 64) ? 15 : 13;
    h = c == 0 ? 0 : 63 + c;
    v = vf + k % (512 - vf);
    fr = (k / (512 - vf)) % 256;
    hb = h[6:0];
    vb = v[8:0];
    fb = fr[7:0];
    hbl = !(hb[5] || (hb[4] && hb[3]));
    vbl = !vb[8] || (vb[7] && vb[6]);
    hs = hbl && hb[3] && !hb[2];
    vs = vbl && vb[5:2] == 4'b1000 && (hb[5] || hb[4] || hb[3]);
    q3 = ph <= 3 || (ph >= 7 && ph <= 10);
    if (t < 14) gt = 8'b1110_0100;
    else gt = {hbl, vbl, hbl || vbl, hs, vs, !(hs || vs), hbl && hb[3] && hb[2] && g != 1, p == 0 && v == vl};
    return {t[0], t[1], q3, ph >= 7, ph == fin, hb, vb, gt, fb};
  endfunction

  task automatic push_exp(int t);
    exp_t e;
    for (int g = 0; g < 3; g++) e[g] = model(t, g);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int g = 0; g < 3; g++) check($sformatf("%s%0d", tag, g), obs[g], e[g]);
  endtask

  task automatic tick();
    @(posedge CLK_14M);
    n++;
    push_exp(n);
    @(negedge CLK_14M);
    pop_cmp("cyc");
  endtask

  task automatic hold();
    @(posedge CLK_14M);
    push_exp(0);
    @(negedge CLK_14M);
    pop_cmp("rst");
  endtask

  task automatic track();
    if (obs[0][32] && first_ce < 0) first_ce = n;
    for (int g = 0; g < 2; g++) begin
      if (obs[g][12] && !prev_hs[g]) begin
        if (last_hs[g] >= 0) check($sformatf("hs_gap%0d", g), n - last_hs[g], g == 1 ? 910 : 912);
        last_hs[g] = n;
      end
      prev_hs[g] = obs[g][12];
    end
    if (n < 60192) begin
      if (obs[0][8]) vint0++;
      if (obs[0][32] && !obs[0][13]) wnd0++;
    end
    if (n == 60192) begin
      check("vint_per_frame", vint0, 1);
      check("wndw_cycles", wnd0, 80);
      check("frame_cnt", obs[0][7:0], 1);
    end
    if (obs[2][8]) vint2++;
    if (int'(obs[2][24:16]) < vmin) vmin = int'(obs[2][24:16]);
  endtask

  initial begin
    @(negedge CLK_14M);
    push_exp(0);
    pop_cmp("por");
    hold();
    hold();
    RESET_N = 1'b1;
    repeat (905) tick();
    #2 RESET_N = 1'b0;
    #1 push_exp(0);
    pop_cmp("arst");
    n = 0;
    repeat (3) hold();
    RESET_N = 1'b1;
    first_ce = -1;
    vint0 = 0;
    wnd0 = 0;
    vint2 = 0;
    vmin = 511;
    last_hs = '{-1, -1};
    prev_hs = '0;
    repeat (62200) begin
      tick();
      track();
    end
    check("first_ce", first_ce, 13);
    check("ntsc_vint_none", vint2, 0);
    check("ntsc_vmin_ok", vmin >= 'h0FA, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
